// File: rtl/irq_pkg.sv
// irq_pkg: register offsets, FSM states and CAUSE layout for irq_sb_ctrl
package irq_pkg;
    localparam logic [31:0] IRQ_MASK_OFF  = 32'h00;
    localparam logic [31:0] IRQ_PEND_OFF  = 32'h04;
    localparam logic [31:0] IRQ_CAUSE_OFF = 32'h08;
    localparam int CAUSE_VLD_BIT = 31;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} irq_state_t;
endpackage

// File: rtl/irq_prio_pick.sv
// irq_prio_pick: first set bit of vec_i searching upward from base_i, wrapping at N_SRC
module irq_prio_pick #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_SRC-1:0] vec_i,
    input  logic [ID_W-1:0]  base_i,
    output logic             any_o,
    output logic [ID_W-1:0]  id_o
);
    logic [2*N_SRC-1:0] dbl;
    logic [ID_W:0]      sum;
    always_comb begin
        dbl   = {vec_i, vec_i} >> base_i;
        any_o = 1'b0;
        sum   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                any_o = 1'b1;
                sum   = (ID_W+1)'(base_i) + (ID_W+1)'(i);
            end
        end
        if (sum >= (ID_W+1)'(N_SRC)) sum = sum - (ID_W+1)'(N_SRC);
        id_o = sum[ID_W-1:0];
    end
endmodule

// File: rtl/irq_sb_ctrl.sv
// irq_sb_ctrl: bus-mapped interrupt controller with masking and single-winner service
// IRQ_ROUND_ROBIN_EN selects round-robin priority; otherwise lowest index wins.
module irq_sb_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      write_data_i,
    output logic [31:0]      read_data_o,
    input  logic [N_SRC-1:0] irq_src_i,
    output logic [N_SRC-1:0] irq_ret_o,
    output logic             irq_req_o,
    input  logic             irq_ret_i
);
    irq_state_t        state_q, state_d;
    logic [N_SRC-1:0]  mask_q, mask_d, ret_q, ret_d, pend;
    logic [ID_W-1:0]   id_q, id_d, base, pick_id;
    logic [31:0]       rd_q, rd_d, cause;
    logic              irq_req_q, irq_req_d, pick_any;
    logic              unused_wdata;

    assign unused_wdata = ^write_data_i;
    assign pend = irq_src_i & mask_q;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_q, rr_d;
    assign base = rr_q;
    always_comb begin
        rr_d = rr_q;
        if (state_q == DRAIN)
            rr_d = (id_q == ID_W'(N_SRC - 1)) ? '0 : id_q + 1'b1;
    end
    always_ff @(posedge clk_i) rr_q <= !resetn_i ? '0 : rr_d;
`else
    assign base = '0;
`endif

    irq_prio_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
        .vec_i (pend),
        .base_i(base),
        .any_o (pick_any),
        .id_o  (pick_id)
    );

    always_comb begin
        cause = '0;
        cause[CAUSE_VLD_BIT] = (state_q == ACTIVE);
        cause[ID_W-1:0] = id_q;
        mask_d = (req_i && write_enable_i && addr_i == IRQ_MASK_OFF) ? write_data_i[N_SRC-1:0] : mask_q;
        rd_d = rd_q;
        if (req_i && !write_enable_i)
            rd_d = (addr_i == IRQ_MASK_OFF)  ? 32'(mask_q) :
                   (addr_i == IRQ_PEND_OFF)  ? 32'(pend)   :
                   (addr_i == IRQ_CAUSE_OFF) ? cause       : '0;
        state_d   = state_q;
        id_d      = id_q;
        irq_req_d = 1'b0;
        ret_d     = '0;
        // Service completes on the core's return regardless of the source's current level or mask.
        case (state_q)
            IDLE: if (pick_any) begin
                state_d   = ACTIVE;
                id_d      = pick_id;
                irq_req_d = 1'b1;
            end
            ACTIVE: begin
                irq_req_d = !irq_ret_i;
                if (irq_ret_i) begin
                    state_d = DRAIN;
                    ret_d   = N_SRC'(1) << id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q   <= IDLE;
            id_q      <= '0;
            mask_q    <= '0;
            rd_q      <= '0;
            irq_req_q <= 1'b0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            mask_q    <= mask_d;
            rd_q      <= rd_d;
            irq_req_q <= irq_req_d;
            ret_q     <= ret_d;
        end
    end

    assign read_data_o = rd_q;
    assign irq_req_o   = irq_req_q;
    assign irq_ret_o   = ret_q;
endmodule

// File: tb/tb_irq_sb_ctrl.sv
// tb_irq_sb_ctrl: directed checks of register access, service cycle, arbitration and masking
module tb_irq_sb_ctrl;
    logic        clk_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic        req_i = 1'b0;
    logic        write_enable_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] write_data_i = '0;
    logic [31:0] read_data_o;
    logic [7:0]  irq_src_i = '0;
    logic [7:0]  irq_ret_o;
    logic        irq_req_o;
    logic        irq_ret_i = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] rd;

    irq_sb_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .req_i(req_i), .write_enable_i(write_enable_i),
        .addr_i(addr_i), .write_data_i(write_data_i), .read_data_o(read_data_o),
        .irq_src_i(irq_src_i), .irq_ret_o(irq_ret_o), .irq_req_o(irq_req_o), .irq_ret_i(irq_ret_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
        @(negedge clk_i);
        req_i = 1'b0; write_enable_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_i);
        req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        req_i = 1'b0;
        d = read_data_o;
    endtask

    task automatic test_reset;
        resetn_i = 1'b0; irq_src_i = 8'hFF;
        repeat (3) @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b0) $display("FAIL rst_req got %b exp 0", irq_req_o); else n_pass++;
        n_total++; if (irq_ret_o !== 8'h00) $display("FAIL rst_ret got %h exp 00", irq_ret_o); else n_pass++;
        n_total++; if (read_data_o !== 32'h0) $display("FAIL rst_rdata got %h exp 0", read_data_o); else n_pass++;
        irq_src_i = 8'h00; resetn_i = 1'b1;
        bus_read(32'h00, rd);
        n_total++; if (rd !== 32'h0) $display("FAIL rst_mask got %h exp 0", rd); else n_pass++;
        bus_read(32'h08, rd);
        n_total++; if (rd !== 32'h0) $display("FAIL rst_cause got %h exp 0", rd); else n_pass++;
    endtask

    task automatic test_single;
        bus_write(32'h00, 32'hFFFF_FF04);
        bus_read(32'h00, rd);
        n_total++; if (rd !== 32'h04) $display("FAIL mask_rd got %h exp 04", rd); else n_pass++;
        irq_src_i = 8'h04;
        #1;
        n_total++; if (irq_req_o !== 1'b0) $display("FAIL single_pre got %b exp 0", irq_req_o); else n_pass++;
        @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b1) $display("FAIL single_req got %b exp 1", irq_req_o); else n_pass++;
        bus_read(32'h08, rd);
        n_total++; if (rd !== 32'h8000_0002) $display("FAIL single_cause got %h exp 80000002", rd); else n_pass++;
        irq_ret_i = 1'b1;
        @(negedge clk_i);
        irq_ret_i = 1'b0; irq_src_i = 8'h00;
        n_total++; if (irq_ret_o !== 8'h04) $display("FAIL single_ret got %h exp 04", irq_ret_o); else n_pass++;
        n_total++; if (irq_req_o !== 1'b0) $display("FAIL single_drain got %b exp 0", irq_req_o); else n_pass++;
        @(negedge clk_i);
        n_total++; if (irq_ret_o !== 8'h00) $display("FAIL single_ret_once got %h exp 00", irq_ret_o); else n_pass++;
    endtask

    task automatic test_masking;
        bus_write(32'h00, 32'h0);
        irq_src_i = 8'h08;
        repeat (3) @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b0) $display("FAIL masked_req got %b exp 0", irq_req_o); else n_pass++;
        bus_read(32'h04, rd);
        n_total++; if (rd !== 32'h0) $display("FAIL masked_pend got %h exp 0", rd); else n_pass++;
        bus_write(32'h00, 32'h08);
        n_total++; if (irq_req_o !== 1'b0) $display("FAIL unmask_early got %b exp 0", irq_req_o); else n_pass++;
        @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b1) $display("FAIL unmask_req got %b exp 1", irq_req_o); else n_pass++;
        bus_read(32'h04, rd);
        n_total++; if (rd !== 32'h08) $display("FAIL pend got %h exp 08", rd); else n_pass++;
        bus_write(32'h04, 32'hFF);
        bus_read(32'h00, rd);
        n_total++; if (rd !== 32'h08) $display("FAIL ro_write got %h exp 08", rd); else n_pass++;
        irq_ret_i = 1'b1;
        @(negedge clk_i);
        irq_ret_i = 1'b0; irq_src_i = 8'h00;
        n_total++; if (irq_ret_o !== 8'h08) $display("FAIL mask_ret got %h exp 08", irq_ret_o); else n_pass++;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_arbitration;
        logic [7:0] first, second;
`ifdef IRQ_ROUND_ROBIN_EN
        first = 8'h10; second = 8'h02;
`else
        first = 8'h02; second = 8'h10;
`endif
        bus_write(32'h00, 32'hFF);
        irq_src_i = 8'h12;
        @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b1) $display("FAIL arb_req1 got %b exp 1", irq_req_o); else n_pass++;
        irq_ret_i = 1'b1;
        @(negedge clk_i);
        irq_ret_i = 1'b0;
        n_total++; if (irq_ret_o !== first) $display("FAIL arb_first got %h exp %h", irq_ret_o, first); else n_pass++;
        irq_src_i = irq_src_i & ~first;
        @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b0) $display("FAIL arb_drain got %b exp 0", irq_req_o); else n_pass++;
        @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b1) $display("FAIL arb_req2 got %b exp 1", irq_req_o); else n_pass++;
        irq_ret_i = 1'b1;
        @(negedge clk_i);
        irq_ret_i = 1'b0; irq_src_i = 8'h00;
        n_total++; if (irq_ret_o !== second) $display("FAIL arb_second got %h exp %h", irq_ret_o, second); else n_pass++;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_mid_service;
        irq_src_i = 8'h01;
        repeat (2) @(negedge clk_i);
        irq_src_i = 8'h00;
        bus_write(32'h00, 32'h0);
        @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b1) $display("FAIL drop_req got %b exp 1", irq_req_o); else n_pass++;
        bus_read(32'h08, rd);
        n_total++; if (rd !== 32'h8000_0000) $display("FAIL drop_cause got %h exp 80000000", rd); else n_pass++;
        @(negedge clk_i);
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = 32'h00; write_data_i = 32'hA5; irq_ret_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0; write_enable_i = 1'b0; irq_ret_i = 1'b0;
        n_total++; if (irq_ret_o !== 8'h01) $display("FAIL drop_ret got %h exp 01", irq_ret_o); else n_pass++;
        bus_read(32'h00, rd);
        n_total++; if (rd !== 32'hA5) $display("FAIL ret_mask_wr got %h exp a5", rd); else n_pass++;
        irq_ret_i = 1'b1;
        @(negedge clk_i);
        irq_ret_i = 1'b0;
        n_total++; if (irq_ret_o !== 8'h00) $display("FAIL idle_ret got %h exp 00", irq_ret_o); else n_pass++;
        @(negedge clk_i);
        n_total++; if (irq_ret_o !== 8'h00 || irq_req_o !== 1'b0) $display("FAIL idle_ret2 got %h/%b exp 00/0", irq_ret_o, irq_req_o); else n_pass++;
    endtask

    task automatic test_reset_active;
        bus_write(32'h00, 32'hFF);
        irq_src_i = 8'h20;
        @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b1) $display("FAIL ra_req got %b exp 1", irq_req_o); else n_pass++;
        resetn_i = 1'b0; irq_ret_i = 1'b1;
        @(negedge clk_i);
        n_total++; if (irq_req_o !== 1'b0) $display("FAIL ra_req_drop got %b exp 0", irq_req_o); else n_pass++;
        n_total++; if (irq_ret_o !== 8'h00) $display("FAIL ra_ret got %h exp 00", irq_ret_o); else n_pass++;
        resetn_i = 1'b1; irq_ret_i = 1'b0;
        bus_read(32'h08, rd);
        n_total++; if (rd[31] !== 1'b0) $display("FAIL ra_cause got %h exp bit31=0", rd); else n_pass++;
        irq_src_i = 8'h00;
    endtask

    initial begin
        test_reset;
        test_single;
        test_masking;
        test_arbitration;
        test_mid_service;
        test_reset_active;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
